// File: rtl/cv32e40p_recovery_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cv32e40p_recovery_pkg
// Purpose  : Shared types and helpers for the rollback recovery sequencer.
//            - recovery_state_e   : top-level sequencer states
//            - recovery_num_beats : number of restore beats for a given
//                                   register count and write-port count
//            - RECOVERY_SETBACK_CYCLES_DEFAULT : default setback hold length
// Revision : 1.0 - initial release
// ============================================================================
package cv32e40p_recovery_pkg;

    localparam int unsigned RECOVERY_SETBACK_CYCLES_DEFAULT = 2;

    typedef enum logic [2:0] {
        RS_IDLE    = 3'd0,
        RS_SETBACK = 3'd1,
        RS_RESTORE = 3'd2,
        RS_DRAIN   = 3'd3,
        RS_PC      = 3'd4,
        RS_DONE    = 3'd5
    } recovery_state_e;

    // x0 is never restored, so NUM_REGS-1 registers are spread over the ports.
    function automatic int unsigned recovery_num_beats(input int unsigned num_regs,
                                                       input int unsigned num_wports);
        return (num_regs - 1 + num_wports - 1) / num_wports;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cv32e40p_recovery_rf_streamer.sv
`default_nettype none
// ============================================================================
// Module   : cv32e40p_recovery_rf_streamer
// Purpose  : Streams architectural registers x1..x(NUM_REGS-1) from the
//            shadow store into the core register-file write ports.
//            A start pulse launches NB read beats on consecutive cycles;
//            each beat's write appears on the RF ports one cycle later.
// Ports    : clk_i/rst_ni      clock, async active-low reset
//            start_i           launch the beat sequence (one-cycle pulse)
//            last_beat_o       current cycle is the final read beat
//            bk_re_o/raddr_o   shadow-store read request
//            bk_rdata_i        shadow-store data (1-cycle latency)
//            rf_we_o/waddr_o   registered RF write enables / addresses
//            rf_wdata_o        RF write data, combinational from bk_rdata_i
// Revision : 1.0 - initial release
// ============================================================================
module cv32e40p_recovery_rf_streamer
    import cv32e40p_recovery_pkg::*;
#(
    parameter int unsigned NUM_REGS   = 32,
    parameter int unsigned NUM_WPORTS = 2,
    parameter int unsigned ADDR_W     = $clog2(NUM_REGS)
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         start_i,
    output logic                         last_beat_o,
    output logic                         bk_re_o,
    output logic [NUM_WPORTS*ADDR_W-1:0] bk_raddr_o,
    input  logic [NUM_WPORTS*32-1:0]     bk_rdata_i,
    output logic [NUM_WPORTS-1:0]        rf_we_o,
    output logic [NUM_WPORTS*ADDR_W-1:0] rf_waddr_o,
    output logic [NUM_WPORTS*32-1:0]     rf_wdata_o
);

    localparam int unsigned NB  = recovery_num_beats(NUM_REGS, NUM_WPORTS);
    localparam int unsigned CW  = $clog2(NB + 1);
    // One spare bit so addresses just past NUM_REGS-1 compare as invalid
    // instead of wrapping back onto low registers.
    localparam int unsigned AW1 = ADDR_W + 1;

    logic                         active_q, active_d;
    logic [CW-1:0]                cnt_q, cnt_d;
    logic [NUM_WPORTS-1:0]        lane_valid;
    logic [NUM_WPORTS*ADDR_W-1:0] raddr;
    logic [NUM_WPORTS-1:0]        we_q, we_d;
    logic [NUM_WPORTS*ADDR_W-1:0] waddr_q, waddr_d;

    assign last_beat_o = active_q && (cnt_q == CW'(NB - 1));

    always_comb begin
        active_d = active_q;
        cnt_d    = cnt_q;
        if (start_i) begin
            active_d = 1'b1;
            cnt_d    = '0;
        end else if (active_q) begin
            if (last_beat_o) begin
                active_d = 1'b0;
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    for (genvar p = 0; p < NUM_WPORTS; p++) begin : g_lane
        logic [AW1-1:0] addr_wide;
        assign addr_wide = AW1'(1 + p) + AW1'(cnt_q) * AW1'(NUM_WPORTS);
        assign lane_valid[p] = addr_wide < AW1'(NUM_REGS);
        // Invalid or idle lanes drive address 0 so nothing stray reaches x1..
        assign raddr[p*ADDR_W +: ADDR_W] = (active_q && lane_valid[p]) ?
                                           addr_wide[ADDR_W-1:0] : '0;
        // Data is only meaningful on a write cycle; keep it quiet otherwise.
        assign rf_wdata_o[p*32 +: 32] = we_q[p] ? bk_rdata_i[p*32 +: 32] : 32'h0;
    end

    assign we_d    = active_q ? lane_valid : '0;
    assign waddr_d = raddr;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
            we_q     <= '0;
            waddr_q  <= '0;
        end else begin
            active_q <= active_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            waddr_q  <= waddr_d;
        end
    end

    assign bk_re_o    = active_q;
    assign bk_raddr_o = raddr;
    assign rf_we_o    = we_q;
    assign rf_waddr_o = waddr_q;

endmodule
`default_nettype wire

// File: rtl/cv32e40p_recovery_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cv32e40p_recovery_ctrl
// Purpose  : Rollback sequencer for the fault-tolerant cv32e40p wrapper.
//            Keeps a PC/branch checkpoint; on a recovery request holds the
//            core in setback, restores the register file from the shadow
//            store, restores PC/branch state and pulses completion.
// Ports    : clk_i/rst_ni                  clock, async active-low reset
//            checkpoint_en_i, *_backup_i   checkpoint capture (IDLE only)
//            recover_req_i                 start request (sampled in IDLE)
//            busy_o/done_o/setback_o       sequence status, core setback
//            bk_re_o/bk_raddr_o/bk_rdata_i shadow-store read port
//            rf_recover_o/rf_we_o/...      core RF recovery write ports
//            pc_recover_o/recovery_*_o     core PC recovery
// Revision : 1.0 - initial release
// ============================================================================
module cv32e40p_recovery_ctrl
    import cv32e40p_recovery_pkg::*;
#(
    parameter int unsigned NUM_REGS       = 32,
    parameter int unsigned NUM_WPORTS     = 2,
    parameter int unsigned SETBACK_CYCLES = RECOVERY_SETBACK_CYCLES_DEFAULT,
    parameter int unsigned ADDR_W         = $clog2(NUM_REGS)
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         checkpoint_en_i,
    input  logic [31:0]                  pc_backup_i,
    input  logic                         branch_backup_i,
    input  logic [31:0]                  branch_addr_backup_i,
    input  logic                         recover_req_i,
    output logic                         busy_o,
    output logic                         done_o,
    output logic                         setback_o,
    output logic                         bk_re_o,
    output logic [NUM_WPORTS*ADDR_W-1:0] bk_raddr_o,
    input  logic [NUM_WPORTS*32-1:0]     bk_rdata_i,
    output logic                         rf_recover_o,
    output logic [NUM_WPORTS-1:0]        rf_we_o,
    output logic [NUM_WPORTS*ADDR_W-1:0] rf_waddr_o,
    output logic [NUM_WPORTS*32-1:0]     rf_wdata_o,
    output logic                         pc_recover_o,
    output logic [31:0]                  recovery_pc_o,
    output logic                         recovery_branch_o,
    output logic [31:0]                  recovery_branch_addr_o
);

    localparam int unsigned SB_CNT_W = $clog2(SETBACK_CYCLES + 1);

    recovery_state_e       state_q, state_d;
    logic [SB_CNT_W-1:0]   sb_cnt_q, sb_cnt_d;
    logic                  start;
    logic                  last_beat;

    logic [31:0]           ckpt_pc_q;
    logic                  ckpt_branch_q;
    logic [31:0]           ckpt_baddr_q;
    logic                  ckpt_capture;

    // Checkpoint only moves while idle, so a capture that lands in the same
    // cycle as a request is what the following sequence restores.
    assign ckpt_capture = (state_q == RS_IDLE) && checkpoint_en_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ckpt_pc_q     <= 32'h0;
            ckpt_branch_q <= 1'b0;
            ckpt_baddr_q  <= 32'h0;
        end else if (ckpt_capture) begin
            ckpt_pc_q     <= pc_backup_i;
            ckpt_branch_q <= branch_backup_i;
            ckpt_baddr_q  <= branch_addr_backup_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= RS_IDLE;
            sb_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            sb_cnt_q <= sb_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        sb_cnt_d     = sb_cnt_q;
        start        = 1'b0;
        busy_o       = 1'b0;
        done_o       = 1'b0;
        setback_o    = 1'b0;
        rf_recover_o = 1'b0;
        pc_recover_o = 1'b0;
        case (state_q)
            RS_IDLE: begin
                if (recover_req_i) begin
                    state_d  = RS_SETBACK;
                    sb_cnt_d = SB_CNT_W'(SETBACK_CYCLES);
                end
            end
            RS_SETBACK: begin
                busy_o    = 1'b1;
                setback_o = 1'b1;
                // The streamer is launched on the final setback cycle so the
                // first read beat lands in the first RESTORE cycle.
                if (sb_cnt_q == SB_CNT_W'(1)) begin
                    state_d  = RS_RESTORE;
                    sb_cnt_d = '0;
                    start    = 1'b1;
                end else begin
                    sb_cnt_d = sb_cnt_q - SB_CNT_W'(1);
                end
            end
            RS_RESTORE: begin
                busy_o       = 1'b1;
                rf_recover_o = 1'b1;
                if (last_beat) begin
                    state_d = RS_DRAIN;
                end
            end
            RS_DRAIN: begin
                // Carries the write of the final beat.
                busy_o       = 1'b1;
                rf_recover_o = 1'b1;
                state_d      = RS_PC;
            end
            RS_PC: begin
                busy_o       = 1'b1;
                pc_recover_o = 1'b1;
                state_d      = RS_DONE;
            end
            RS_DONE: begin
                done_o  = 1'b1;
                state_d = RS_IDLE;
            end
            default: begin
                state_d = RS_IDLE;
            end
        endcase
    end

    cv32e40p_recovery_rf_streamer #(
        .NUM_REGS   (NUM_REGS),
        .NUM_WPORTS (NUM_WPORTS),
        .ADDR_W     (ADDR_W)
    ) u_streamer (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .start_i     (start),
        .last_beat_o (last_beat),
        .bk_re_o     (bk_re_o),
        .bk_raddr_o  (bk_raddr_o),
        .bk_rdata_i  (bk_rdata_i),
        .rf_we_o     (rf_we_o),
        .rf_waddr_o  (rf_waddr_o),
        .rf_wdata_o  (rf_wdata_o)
    );

    assign recovery_pc_o          = ckpt_pc_q;
    assign recovery_branch_o      = ckpt_branch_q;
    assign recovery_branch_addr_o = ckpt_baddr_q;

endmodule
`default_nettype wire

// File: tb/tb_cv32e40p_recovery_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_cv32e40p_recovery_ctrl
// Purpose  : Self-checking bench for cv32e40p_recovery_ctrl. Two instances:
//            A = 32 regs / 2 ports / 2 setback cycles,
//            B = 64 regs / 1 port  / 1 setback cycle (ADDR_W 6).
//            Expected behaviour is computed from the sequence timeline
//            (cycle offsets after the request) and a checkpoint model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cv32e40p_recovery_ctrl;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    logic [31:0] pc_in = '0;
    logic        br_in = 1'b0;
    logic [31:0] ba_in = '0;
    logic a_req = 1'b0, a_ckpt = 1'b0, b_req = 1'b0, b_ckpt = 1'b0;

    logic        a_busy, a_done, a_setback, a_bk_re, a_rf_rec, a_pc_rec, a_rbr;
    logic [9:0]  a_raddr, a_waddr;
    logic [1:0]  a_we;
    logic [63:0] a_rdata = '0;
    logic [63:0] a_wdata;
    logic [31:0] a_rpc, a_rba;

    logic        b_busy, b_done, b_setback, b_bk_re, b_rf_rec, b_pc_rec, b_rbr;
    logic [5:0]  b_raddr, b_waddr;
    logic [0:0]  b_we;
    logic [31:0] b_rdata = '0;
    logic [31:0] b_wdata, b_rpc, b_rba;

    logic [31:0] mem [64];
    logic [31:0] m_pc [2];
    logic        m_br [2];
    logic [31:0] m_ba [2];

    cv32e40p_recovery_ctrl #(
        .NUM_REGS(32), .NUM_WPORTS(2), .SETBACK_CYCLES(2)
    ) dut_a (
        .clk_i(clk), .rst_ni(rst_n),
        .checkpoint_en_i(a_ckpt), .pc_backup_i(pc_in),
        .branch_backup_i(br_in), .branch_addr_backup_i(ba_in),
        .recover_req_i(a_req), .busy_o(a_busy), .done_o(a_done), .setback_o(a_setback),
        .bk_re_o(a_bk_re), .bk_raddr_o(a_raddr), .bk_rdata_i(a_rdata),
        .rf_recover_o(a_rf_rec), .rf_we_o(a_we), .rf_waddr_o(a_waddr), .rf_wdata_o(a_wdata),
        .pc_recover_o(a_pc_rec), .recovery_pc_o(a_rpc),
        .recovery_branch_o(a_rbr), .recovery_branch_addr_o(a_rba)
    );

    cv32e40p_recovery_ctrl #(
        .NUM_REGS(64), .NUM_WPORTS(1), .SETBACK_CYCLES(1), .ADDR_W(6)
    ) dut_b (
        .clk_i(clk), .rst_ni(rst_n),
        .checkpoint_en_i(b_ckpt), .pc_backup_i(pc_in),
        .branch_backup_i(br_in), .branch_addr_backup_i(ba_in),
        .recover_req_i(b_req), .busy_o(b_busy), .done_o(b_done), .setback_o(b_setback),
        .bk_re_o(b_bk_re), .bk_raddr_o(b_raddr), .bk_rdata_i(b_rdata),
        .rf_recover_o(b_rf_rec), .rf_we_o(b_we), .rf_waddr_o(b_waddr), .rf_wdata_o(b_wdata),
        .pc_recover_o(b_pc_rec), .recovery_pc_o(b_rpc),
        .recovery_branch_o(b_rbr), .recovery_branch_addr_o(b_rba)
    );

    // Shadow store: one-cycle read latency per lane.
    always @(posedge clk) begin
        if (a_bk_re) begin
            a_rdata[31:0]  <= mem[a_raddr[4:0]];
            a_rdata[63:32] <= mem[a_raddr[9:5]];
        end
        if (b_bk_re) begin
            b_rdata <= mem[b_raddr];
        end
    end

    // Uniform view of whichever instance is under test.
    int          sel = 0;
    logic        v_busy, v_done, v_setback, v_bk_re, v_rf_rec, v_pc_rec, v_rbr;
    logic [1:0]  v_we;
    logic [5:0]  v_raddr [2];
    logic [5:0]  v_waddr [2];
    logic [31:0] v_wdata [2];
    logic [31:0] v_rpc, v_rba;

    always_comb begin
        if (sel == 1) begin
            v_busy = b_busy; v_done = b_done; v_setback = b_setback; v_bk_re = b_bk_re;
            v_rf_rec = b_rf_rec; v_pc_rec = b_pc_rec; v_rbr = b_rbr;
            v_we = {1'b0, b_we};
            v_raddr[0] = b_raddr;  v_raddr[1] = 6'd0;
            v_waddr[0] = b_waddr;  v_waddr[1] = 6'd0;
            v_wdata[0] = b_wdata;  v_wdata[1] = 32'h0;
            v_rpc = b_rpc; v_rba = b_rba;
        end else begin
            v_busy = a_busy; v_done = a_done; v_setback = a_setback; v_bk_re = a_bk_re;
            v_rf_rec = a_rf_rec; v_pc_rec = a_pc_rec; v_rbr = a_rbr;
            v_we = a_we;
            v_raddr[0] = {1'b0, a_raddr[4:0]}; v_raddr[1] = {1'b0, a_raddr[9:5]};
            v_waddr[0] = {1'b0, a_waddr[4:0]}; v_waddr[1] = {1'b0, a_waddr[9:5]};
            v_wdata[0] = a_wdata[31:0];        v_wdata[1] = a_wdata[63:32];
            v_rpc = a_rpc; v_rba = a_rba;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int d, input logic v);
        if (d == 1) b_req = v; else a_req = v;
    endtask

    task automatic set_ckpt(input int d, input logic v);
        if (d == 1) b_ckpt = v; else a_ckpt = v;
    endtask

    task automatic drive_ckpt(input int d, input logic [31:0] pc, input bit track);
        pc_in = pc;
        br_in = 1'($urandom);
        ba_in = $urandom;
        set_ckpt(d, 1'b1);
        if (track) begin
            m_pc[d] = pc_in; m_br[d] = br_in; m_ba[d] = ba_in;
        end
    endtask

    task automatic chk_recovery(input string tag);
        chk({tag, " rec_pc"}, v_rpc, m_pc[sel]);
        chk({tag, " rec_br"}, v_rbr, m_br[sel]);
        chk({tag, " rec_ba"}, v_rba, m_ba[sel]);
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, " busy"}, v_busy, 0);
        chk({tag, " done"}, v_done, 0);
        chk({tag, " setback"}, v_setback, 0);
        chk({tag, " bk_re"}, v_bk_re, 0);
        chk({tag, " rf_recover"}, v_rf_rec, 0);
        chk({tag, " pc_recover"}, v_pc_rec, 0);
        chk({tag, " we"}, v_we, 0);
        for (int p = 0; p < 2; p++) begin
            chk($sformatf("%s raddr%0d", tag, p), v_raddr[p], 0);
            chk($sformatf("%s waddr%0d", tag, p), v_waddr[p], 0);
            chk($sformatf("%s wdata%0d", tag, p), v_wdata[p], 0);
        end
        chk_recovery(tag);
    endtask

    // Entered just after a negedge with instance d idle. The request is
    // sampled at the next posedge (edge T); offset k counts negedges after it.
    task automatic run_seq(input int d, input bit ckpt_same, input bit hold, input logic [31:0] pc);
        int nregs, nwp, sb, nb, lat, a;
        int wr_cnt [64];
        logic          e_we;
        logic [5:0]    e_addr;
        string         t;
        nregs = (d == 1) ? 64 : 32;
        nwp   = (d == 1) ? 1 : 2;
        sb    = (d == 1) ? 1 : 2;
        nb    = (nregs - 1 + nwp - 1) / nwp;
        lat   = sb + nb + 3;
        for (int i = 0; i < 64; i++) wr_cnt[i] = 0;
        sel = d;
        if (ckpt_same) drive_ckpt(d, pc, 1'b1);
        set_req(d, 1'b1);
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            if (k == 1) begin
                if (!hold) set_req(d, 1'b0);
                set_ckpt(d, 1'b0);
            end
            if (k == 4) drive_ckpt(d, $urandom, 1'b0);
            if (k == 5) set_ckpt(d, 1'b0);
            t = $sformatf("d%0d k%0d", d, k);
            chk({t, " setback"}, v_setback, (k <= sb));
            chk({t, " busy"}, v_busy, (k <= lat - 1));
            chk({t, " done"}, v_done, (k == lat));
            chk({t, " rf_recover"}, v_rf_rec, (k > sb && k <= sb + nb + 1));
            chk({t, " pc_recover"}, v_pc_rec, (k == sb + nb + 2));
            chk({t, " bk_re"}, v_bk_re, (k > sb && k <= sb + nb));
            for (int p = 0; p < 2; p++) begin
                e_addr = 6'd0;
                if (p < nwp && k > sb && k <= sb + nb) begin
                    a = 1 + (k - sb - 1) * nwp + p;
                    if (a < nregs) e_addr = 6'(a);
                end
                chk($sformatf("%s raddr%0d", t, p), v_raddr[p], e_addr);
                e_we   = 1'b0;
                e_addr = 6'd0;
                if (p < nwp && k >= sb + 2 && k <= sb + nb + 1) begin
                    a = 1 + (k - sb - 2) * nwp + p;
                    if (a < nregs) begin
                        e_we   = 1'b1;
                        e_addr = 6'(a);
                    end
                end
                chk($sformatf("%s we%0d", t, p), v_we[p], e_we);
                chk($sformatf("%s waddr%0d", t, p), v_waddr[p], e_addr);
                if (e_we) chk($sformatf("%s wdata%0d", t, p), v_wdata[p], mem[e_addr]);
                if (v_we[p]) wr_cnt[v_waddr[p]]++;
            end
            if (k == sb + nb + 2) chk_recovery(t);
        end
        @(negedge clk);
        t = $sformatf("d%0d idle", d);
        chk({t, " busy"}, v_busy, 0);
        chk({t, " done"}, v_done, 0);
        chk({t, " setback"}, v_setback, 0);
        chk({t, " we"}, v_we, 0);
        for (int i = 0; i < nregs; i++) begin
            chk($sformatf("d%0d writes x%0d", d, i), wr_cnt[i], (i == 0) ? 0 : 1);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 | 32'(i);
        for (int d = 0; d < 2; d++) begin
            m_pc[d] = '0; m_br[d] = 1'b0; m_ba[d] = '0;
        end

        // Reset state of both instances.
        #3;
        sel = 0; #1; check_quiet("rst0 a");
        sel = 1; #1; check_quiet("rst0 b");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Same-cycle checkpoint + request, busy checkpoint pulse ignored.
        run_seq(0, 1'b1, 1'b0, 32'h0000_1234);
        // No new checkpoint: previous values restored.
        run_seq(0, 1'b0, 1'b0, 32'h0);

        // Checkpoint alone while idle updates recovery outputs.
        sel = 0;
        drive_ckpt(0, $urandom, 1'b1);
        @(negedge clk);
        a_ckpt = 1'b0;
        chk_recovery("idle ckpt");

        // Random shadow data; request held high across two sequences.
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        run_seq(0, 1'b1, 1'b1, $urandom);
        run_seq(0, 1'b0, 1'b0, 32'h0);

        // Single-port 64-register instance.
        run_seq(1, 1'b1, 1'b0, $urandom);
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        run_seq(1, 1'b0, 1'b0, 32'h0);

        // Asynchronous reset in the middle of RESTORE.
        sel = 0;
        a_req = 1'b1;
        @(negedge clk);
        a_req = 1'b0;
        repeat (5) @(negedge clk);
        chk("pre-reset rf_recover", v_rf_rec, 1);
        #2;
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            m_pc[d] = '0; m_br[d] = 1'b0; m_ba[d] = '0;
        end
        check_quiet("rst mid a");
        sel = 1; #1; check_quiet("rst mid b");
        sel = 0;
        repeat (3) begin
            @(negedge clk);
            chk("in reset done", v_done, 0);
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post reset busy", v_busy, 0);
            chk("post reset done", v_done, 0);
        end

        // Normal operation resumes after reset.
        run_seq(0, 1'b1, 1'b0, $urandom);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
